// File: rtl/clint_controller.sv
// rtl/clint_controller.sv - core-local interruptor: msip, mtime with prescaler, mtimecmp on a Wishbone-style slave
module clint_controller #(
  parameter int DATA_SIZE             = 64,
  parameter int CLOCK_CYCLES_PER_TICK = 2,
  parameter int ADDR_SIZE             = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wb_cyc,
  input  logic                   wb_stb,
  input  logic                   wb_we,
  input  logic [ADDR_SIZE-1:0]   wb_addr,
  input  logic [DATA_SIZE/8-1:0] wb_sel,
  input  logic [DATA_SIZE-1:0]   wb_dat_i,
  output logic [DATA_SIZE-1:0]   wb_dat_o,
  output logic                   wb_ack,
  output logic                   msip,
  output logic [63:0]            mtime,
  output logic [63:0]            mtimecmp
);

  localparam int BYTES = DATA_SIZE / 8;
  localparam int PW    = (CLOCK_CYCLES_PER_TICK > 1) ? $clog2(CLOCK_CYCLES_PER_TICK) : 1;
  localparam logic [PW-1:0]        PRESC_LAST = PW'(CLOCK_CYCLES_PER_TICK - 1);
  localparam logic [ADDR_SIZE-1:0] MSIP_ADDR  = ADDR_SIZE'(16'h0000);
  localparam logic [ADDR_SIZE-1:0] CMP_ADDR   = ADDR_SIZE'(16'h4000);
  localparam logic [ADDR_SIZE-1:0] TIME_ADDR  = ADDR_SIZE'(16'hBFF8);

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t               state_q, state_d;
  logic                 msip_q, msip_d;
  logic [63:0]          cmp_q, cmp_d;
  logic [63:0]          mtime_q, mtime_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [DATA_SIZE-1:0] dat_q, dat_d;

  logic                 access, wr, rd;
  logic                 hi_half;
  logic [ADDR_SIZE-1:0] blk;
  logic                 hit_msip, hit_cmp, hit_time;
  logic [DATA_SIZE-1:0] lane_mask;
  logic [63:0]          wmask, wdata, rd64;
  logic [DATA_SIZE-1:0] rdata;
  logic                 time_wr;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^wb_addr[2:0];

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      lane_mask[i*8 +: 8] = {8{wb_sel[i]}};
    end
  end

  // Registers are 64 bits wide; a 32-bit bus sees them as two words selected by addr[2].
  generate
    if (DATA_SIZE == 64) begin : g_bus64
      assign hi_half = 1'b0;
      assign wmask   = lane_mask;
      assign wdata   = wb_dat_i;
      assign rdata   = rd64;
    end else begin : g_bus32
      assign hi_half = wb_addr[2];
      assign wmask   = hi_half ? {lane_mask, 32'h0} : {32'h0, lane_mask};
      assign wdata   = {wb_dat_i, wb_dat_i};
      assign rdata   = hi_half ? rd64[63:32] : rd64[31:0];
    end
  endgenerate

  assign blk      = {wb_addr[ADDR_SIZE-1:3], 3'b000};
  assign hit_msip = (blk == MSIP_ADDR) && !hi_half;
  assign hit_cmp  = (blk == CMP_ADDR);
  assign hit_time = (blk == TIME_ADDR);

  assign access  = (state_q == S_IDLE) && wb_cyc && wb_stb;
  assign wr      = access && wb_we;
  assign rd      = access && !wb_we;
  assign time_wr = wr && hit_time && (|wmask);

  always_comb begin
    rd64 = 64'h0;
    if (hit_msip)      rd64 = {63'h0, msip_q};
    else if (hit_cmp)  rd64 = cmp_q;
    else if (hit_time) rd64 = mtime_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (wb_cyc && wb_stb) state_d = S_ACK;
      S_ACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    msip_d  = msip_q;
    cmp_d   = cmp_q;
    dat_d   = dat_q;
    mtime_d = mtime_q;
    presc_d = presc_q;
    if (wr && hit_msip && wmask[0]) msip_d = wdata[0];
    if (wr && hit_cmp) cmp_d = (cmp_q & ~wmask) | (wdata & wmask);
    if (rd) dat_d = rdata;
    // A bus write to mtime overrides the tick and restarts the prescaler phase.
    if (time_wr) begin
      mtime_d = (mtime_q & ~wmask) | (wdata & wmask);
      presc_d = '0;
    end else if (presc_q == PRESC_LAST) begin
      mtime_d = mtime_q + 64'd1;
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      msip_q  <= 1'b0;
      cmp_q   <= '1;
      mtime_q <= '0;
      presc_q <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      msip_q  <= msip_d;
      cmp_q   <= cmp_d;
      mtime_q <= mtime_d;
      presc_q <= presc_d;
      dat_q   <= dat_d;
    end
  end

  assign wb_ack   = (state_q == S_ACK);
  assign wb_dat_o = dat_q;
  assign msip     = msip_q;
  assign mtime    = mtime_q;
  assign mtimecmp = cmp_q;

endmodule

// File: tb/tb_clint_controller.sv
// tb/tb_clint_controller.sv - directed bench for clint_controller, prescaler 2 and prescaler 1 instances
module tb_clint_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [15:0] wb_addr = '0;
  logic [7:0]  wb_sel = '0;
  logic [63:0] wb_dat_i = '0;
  logic [63:0] wb_dat_o, wb_dat_o1;
  logic        wb_ack, wb_ack1, msip, msip1;
  logic [63:0] mtime, mtimecmp, mtime1, mtimecmp1;

  int n_cmp = 0;
  int n_err = 0;
  logic ack_seen;

  always #5 clock = ~clock;

  clint_controller #(.DATA_SIZE(64), .CLOCK_CYCLES_PER_TICK(2), .ADDR_SIZE(16)) dut (
    .clock(clock), .reset(reset), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack(wb_ack), .msip(msip), .mtime(mtime), .mtimecmp(mtimecmp));

  clint_controller #(.DATA_SIZE(64), .CLOCK_CYCLES_PER_TICK(1), .ADDR_SIZE(16)) dut1 (
    .clock(clock), .reset(reset), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o1),
    .wb_ack(wb_ack1), .msip(msip1), .mtime(mtime1), .mtimecmp(mtimecmp1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic we, input logic [15:0] addr, input logic [7:0] sel,
                     input logic [63:0] data);
    @(negedge clock);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_addr = addr; wb_sel = sel; wb_dat_i = data;
    @(posedge clock);
    #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clock);
    check("ack", {63'h0, wb_ack}, 64'h1);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_mtime", mtime, 64'h0);
    check("rst_cmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_msip", {63'h0, msip}, 64'h0);
    check("rst_dat", wb_dat_o, 64'h0);
    reset = 1'b1;
    ack_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      ack_seen = ack_seen | wb_ack;
    end
    check("mtime_10cyc", mtime, 64'd5);
    check("mtime1_10cyc", mtime1, 64'd10);
    check("no_ack", {63'h0, ack_seen}, 64'h0);

    bus(1'b1, 16'h0000, 8'hFF, 64'h0000_0000_FFFF_FFFF);
    check("msip_set", {63'h0, msip}, 64'h1);
    bus(1'b0, 16'h0000, 8'hFF, 64'h0);
    check("msip_rd", wb_dat_o, 64'h1);
    @(negedge clock);
    check("ack_pulse", {63'h0, wb_ack}, 64'h0);
    check("dat_hold", wb_dat_o, 64'h1);

    bus(1'b1, 16'h4000, 8'hFF, 64'h0000_0000_0000_0100);
    bus(1'b0, 16'h4000, 8'hFF, 64'h0);
    check("cmp_rd", wb_dat_o, 64'h100);
    bus(1'b1, 16'h4000, 8'h01, 64'h0000_0000_0000_00AA);
    check("cmp_byte", mtimecmp, 64'h1AA);

    bus(1'b1, 16'hBFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t1_load", mtime1, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t2_load", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clock);
    check("t1_max", mtime1, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t2_hold", mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clock);
    check("t1_wrap", mtime1, 64'h0);
    check("t2_max", mtime, 64'hFFFF_FFFF_FFFF_FFFF);

    bus(1'b1, 16'hBFF8, 8'hFF, 64'h20);
    bus(1'b1, 16'hBFF8, 8'hFF, 64'h10);
    check("wr_vs_tick", mtime, 64'h10);
    @(negedge clock);
    check("presc_restart", mtime, 64'h10);
    @(negedge clock);
    check("tick_after", mtime, 64'h11);

    bus(1'b1, 16'h1234, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    bus(1'b0, 16'h1234, 8'hFF, 64'h0);
    check("unmap_rd", wb_dat_o, 64'h0);
    check("unmap_msip", {63'h0, msip}, 64'h1);
    check("unmap_cmp", mtimecmp, 64'h1AA);
    bus(1'b1, 16'h4000, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF);
    check("sel0_cmp", mtimecmp, 64'h1AA);

    @(negedge clock);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 16'h4000; wb_sel = 8'hFF;
    @(posedge clock);
    #1;
    reset = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clock);
    check("abort_ack", {63'h0, wb_ack}, 64'h0);
    check("abort_dat", wb_dat_o, 64'h0);
    check("abort_msip", {63'h0, msip}, 64'h0);
    check("abort_cmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
    check("abort_mtime", mtime, 64'h0);
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_ack", {63'h0, wb_ack}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
